mmio_io_responder: RTL and testbench
====================================

Name: mmio_io_responder

Overview:
- Memory-mapped I/O responder on the CPU memory interface: same 4-bit address, read/write strobes and 8-bit data as the memory module.
- Decodes two addresses: a data port and a status port.
- Buffers inbound bytes from an external producer in a small FIFO, which the CPU pops by reading.
- Presents CPU-written bytes to an external consumer through a valid/ready holding register.
- The top level muxes `data_out` onto the memory data path when `hit` is asserted.

Parameters:
- DATA_ADDR, 4'hF, address of the data port (read pops RX FIFO, write loads TX register).
- STAT_ADDR, 4'hE, address of the status port (read status, write clears sticky flags).
- FIFO_DEPTH, 4, RX FIFO entries; power of two, 2..8.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- address  input  4  CPU memory address (from AR).
- read  input  1  CPU memory read strobe.
- write  input  1  CPU memory write strobe.
- data_in  input  8  CPU write data (from bus).
- data_out  output  8  read data; 8'h00 when not hit or not reading.
- hit  output  1  combinational; address==DATA_ADDR or address==STAT_ADDR.
- in_data  input  8  producer byte.
- in_valid  input  1  producer byte valid.
- in_ready  output  1  FIFO not full.
- out_data  output  8  TX holding register.
- out_valid  output  1  TX register holds an unconsumed byte.
- out_ready  input  1  consumer accepts byte.

Behaviour:
- Reset (async, immediate):
  - FIFO pointers and count = 0; out_valid = 0; out_data = 8'h00; sticky flags = 0; strobe history = 0.
  - Therefore in_ready = 1 and data_out = 8'h00.
  - Reset mid-transfer discards FIFO contents and any pending TX byte.
- Strobe edge detection: read_q and write_q are registered copies of read and write.
  - An access "fires" on the clock edge where strobe=1 and strobe_q=0, so one access per strobe assertion however long it is held.
  - read and write asserted together: write fires, read ignored for side effects.
- data_out is combinational while read=1 and hit=1:
  - DATA_ADDR: FIFO head byte, or 8'h00 if empty.
  - STAT_ADDR: status byte, laid out as:
    - bit0 rx_avail (count != 0)
    - bit1 rx_full
    - bit2 tx_busy (out_valid)
    - bit3 tx_overflow (sticky)
    - bit4 rx_underflow (sticky)
    - bits7:5 rx_count (0..FIFO_DEPTH, saturating encode)
- RX push: on an edge where in_valid && in_ready, write in_data at the write pointer and advance it (wrap modulo FIFO_DEPTH). in_ready = (count != FIFO_DEPTH).
- RX pop: a read fire at DATA_ADDR with the FIFO non-empty advances the read pointer. If empty: no pointer change, rx_underflow <= 1.
- Push and pop on the same edge: both happen, count unchanged.
  - When full, no push is possible (in_ready = 0); a pop frees the slot for the next cycle.
- TX write: a write fire at DATA_ADDR with out_valid=0 loads out_data <= data_in and sets out_valid <= 1.
  - With out_valid=1: data dropped, out_data unchanged, tx_overflow <= 1.
- TX consume: on an edge with out_valid && out_ready, out_valid <= 0; out_data holds its last value.
  - Write fire and consume on the same edge: the consume takes the old byte; the new byte loads and out_valid stays 1, with no overflow.
- Status write: a write fire at STAT_ADDR with data_in[0]=1 clears tx_overflow and rx_underflow. Other bits are read-only.
- Accesses to non-decoded addresses: no state change, hit = 0.
- Latency:
  - Pushed byte is visible at DATA_ADDR the cycle after the push edge.
  - CPU-written byte appears on out_valid/out_data the cycle after the write fire.

Test Plan:
- Reset, then read STAT_ADDR -> data_out = 8'h00, in_ready = 1, out_valid = 0.
- Push 8'hA1, 8'hB2, 8'hC3, 8'hD4 -> in_ready drops after the 4th; status = 8'h83 (count 4, full, avail). Four read fires at DATA_ADDR -> A1, B2, C3, D4 in order; status then 8'h00.
- Write 8'h5A to DATA_ADDR, hold out_ready = 0 -> out_valid = 1, out_data = 5A. Second write 8'h77 -> out_data stays 5A; status bit3 = 1. Raise out_ready -> out_valid = 0. Write STAT_ADDR 8'h01 -> bit3 clears.
- Read DATA_ADDR with FIFO empty -> data_out = 8'h00, rx_underflow = 1. Hold read high for 5 cycles with 2 bytes queued -> exactly one pop.
- FIFO full with in_valid held at 8'hEE; pop on the same cycle -> next edge pushes EE, count back at 4. Wrap-around: 10 push/pop pairs give correct order.
- Assert reset mid-stream with 3 bytes queued and out_valid = 1 -> immediately count = 0, out_valid = 0, flags = 0; after release, normal operation resumes.

Source files
------------

// File: rtl/mmio_io_responder_if.sv
// Bus bundle for the MMIO responder: the CPU memory-side strobes and data,
// plus the producer (RX) and consumer (TX) byte streams.
interface mmio_io_responder_if;
  logic [3:0] address;
  logic       read;
  logic       write;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       hit;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  // The responder side: sees the CPU strobes and the producer/consumer inputs.
  modport slave (
    input  address, read, write, data_in, in_data, in_valid, out_ready,
    output data_out, hit, in_ready, out_data, out_valid
  );

  // The driving side: CPU, producer and consumer lumped together.
  modport master (
    output address, read, write, data_in, in_data, in_valid, out_ready,
    input  data_out, hit, in_ready, out_data, out_valid
  );
endinterface

// File: rtl/mmio_io_responder.sv
// Memory-mapped I/O responder. A data port pops an RX FIFO on read and loads a
// TX holding register on write; a status port reports FIFO/TX state and lets
// the CPU clear the sticky error flags. Accesses fire once per strobe assertion.
module mmio_io_responder #(
  parameter logic [3:0] DATA_ADDR  = 4'hF,
  parameter logic [3:0] STAT_ADDR  = 4'hE,
  parameter int         FIFO_DEPTH = 4
) (
  input logic             clock,
  input logic             reset,
  mmio_io_responder_if.slave bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic             read_q;
  logic             write_q;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic             tx_overflow;
  logic             rx_underflow;
  logic [7:0]       out_data_r;
  logic             out_valid_r;

  logic       hit_data;
  logic       hit_stat;
  logic       read_fire;
  logic       write_fire;
  logic       rx_empty;
  logic       rx_full;
  logic       push;
  logic       pop;
  logic       consume;
  logic [3:0] count_ext;
  logic [2:0] rx_count;
  logic [7:0] status;

  assign hit_data = (bus.address == DATA_ADDR);
  assign hit_stat = (bus.address == STAT_ADDR);
  assign bus.hit  = hit_data | hit_stat;

  // A simultaneous write wins, so a read only fires when write is low.
  assign read_fire  = bus.read & ~read_q & ~bus.write;
  assign write_fire = bus.write & ~write_q;

  assign rx_empty = (count == '0);
  assign rx_full  = (count == CNT_W'(FIFO_DEPTH));
  assign push     = bus.in_valid & ~rx_full;
  assign pop      = read_fire & hit_data & ~rx_empty;
  assign consume  = out_valid_r & bus.out_ready;

  assign bus.in_ready  = ~rx_full;
  assign bus.out_data  = out_data_r;
  assign bus.out_valid = out_valid_r;

  // Count field is only three bits wide, so a depth-8 FIFO saturates at 7.
  assign count_ext = 4'(count);
  assign rx_count  = (count_ext > 4'd7) ? 3'd7 : count_ext[2:0];
  assign status    = {rx_count, rx_underflow, tx_overflow, out_valid_r,
                      rx_full, ~rx_empty};

  // Read data is combinational and forced to zero unless a decoded read is active.
  always_comb begin
    bus.data_out = 8'h00;
    if (bus.read) begin
      if (hit_data) begin
        bus.data_out = rx_empty ? 8'h00 : fifo_mem[rd_ptr];
      end else if (hit_stat) begin
        bus.data_out = status;
      end
    end
  end

  // Strobe history used to turn level strobes into single-shot access events.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      read_q  <= 1'b0;
      write_q <= 1'b0;
    end else begin
      read_q  <= bus.read;
      write_q <= bus.write;
    end
  end

  // RX storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= bus.in_data;
    end
  end

  // RX pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // TX holding register; a same-edge consume makes room for the incoming byte.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_data_r  <= 8'h00;
      out_valid_r <= 1'b0;
    end else begin
      if (write_fire && hit_data && (!out_valid_r || consume)) begin
        out_data_r  <= bus.data_in;
        out_valid_r <= 1'b1;
      end else if (consume) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  // Sticky error flags, set by bad accesses and cleared by a status write with bit0 set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_overflow  <= 1'b0;
      rx_underflow <= 1'b0;
    end else begin
      if (write_fire && hit_stat && bus.data_in[0]) begin
        tx_overflow  <= 1'b0;
        rx_underflow <= 1'b0;
      end else begin
        if (write_fire && hit_data && out_valid_r && !consume) begin
          tx_overflow <= 1'b1;
        end
        if (read_fire && hit_data && rx_empty) begin
          rx_underflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mmio_io_responder.sv
// Directed-vector bench for mmio_io_responder. Stimulus tasks queue the
// expected CPU read data and TX bytes; a monitor compares them as the DUT
// presents each read access or consumer handshake.
module tb_mmio_io_responder;

  localparam logic [3:0] DATA = 4'hF;
  localparam logic [3:0] STAT = 4'hE;

  logic clock = 1'b0;
  logic reset;

  mmio_io_responder_if bus ();

  mmio_io_responder #(
    .DATA_ADDR (DATA),
    .STAT_ADDR (STAT),
    .FIFO_DEPTH(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // Free-running 10-unit clock.
  always #5 clock = ~clock;

  int         tests_run    = 0;
  int         tests_failed = 0;
  logic [7:0] rd_exp_q [$];
  string      rd_name_q [$];
  logic [7:0] tx_exp_q [$];
  logic       mon_prev_read = 1'b0;

  task automatic check_output(input string name, input logic [7:0] actual,
                              input logic [7:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %02h expected %02h", name, actual, expected);
    end
  endtask

  // Monitor: compare data_out on the first cycle of every read assertion and
  // out_data on every consumer handshake, against the queued expectations.
  always @(negedge clock) begin
    string      n;
    logic [7:0] e;
    if (bus.read && !mon_prev_read) begin
      if (rd_exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_read: got %02h expected no access", bus.data_out);
      end else begin
        n = rd_name_q.pop_front();
        e = rd_exp_q.pop_front();
        check_output(n, bus.data_out, e);
      end
    end
    mon_prev_read = bus.read;
    if (bus.out_valid && bus.out_ready) begin
      if (tx_exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_tx: got %02h expected no handshake", bus.out_data);
      end else begin
        e = tx_exp_q.pop_front();
        check_output("tx_byte", bus.out_data, e);
      end
    end
  end

  task automatic cpu_read_hold(input logic [3:0] a, input logic [7:0] exp,
                               input string name, input int cycles);
    @(posedge clock);
    #1;
    bus.address = a;
    bus.read    = 1'b1;
    rd_exp_q.push_back(exp);
    rd_name_q.push_back(name);
    repeat (cycles) @(posedge clock);
    #1;
    bus.read = 1'b0;
  endtask

  task automatic cpu_read(input logic [3:0] a, input logic [7:0] exp, input string name);
    cpu_read_hold(a, exp, name, 1);
  endtask

  task automatic cpu_write(input logic [3:0] a, input logic [7:0] d);
    @(posedge clock);
    #1;
    bus.address = a;
    bus.data_in = d;
    bus.write   = 1'b1;
    @(posedge clock);
    #1;
    bus.write = 1'b0;
  endtask

  task automatic cpu_read_write(input logic [3:0] a, input logic [7:0] d,
                                input logic [7:0] exp, input string name);
    @(posedge clock);
    #1;
    bus.address = a;
    bus.data_in = d;
    bus.write   = 1'b1;
    bus.read    = 1'b1;
    rd_exp_q.push_back(exp);
    rd_name_q.push_back(name);
    @(posedge clock);
    #1;
    bus.write = 1'b0;
    bus.read  = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] d);
    @(posedge clock);
    #1;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic consume_byte(input logic [7:0] exp);
    tx_exp_q.push_back(exp);
    @(posedge clock);
    #1;
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1;
    bus.out_ready = 1'b0;
  endtask

  // Watchdog so the run always ends even if something stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed sequence.
  initial begin
    reset         = 1'b1;
    bus.address   = 4'h0;
    bus.read      = 1'b0;
    bus.write     = 1'b0;
    bus.data_in   = 8'h00;
    bus.in_data   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset state.
    check_output("reset_in_ready", {7'd0, bus.in_ready}, 8'h01);
    check_output("reset_out_valid", {7'd0, bus.out_valid}, 8'h00);
    check_output("reset_out_data", bus.out_data, 8'h00);
    cpu_read(STAT, 8'h00, "reset_status");

    // Fill the FIFO and drain it in order.
    push_byte(8'hA1);
    push_byte(8'hB2);
    push_byte(8'hC3);
    check_output("in_ready_before_full", {7'd0, bus.in_ready}, 8'h01);
    push_byte(8'hD4);
    check_output("in_ready_full", {7'd0, bus.in_ready}, 8'h00);
    cpu_read(STAT, 8'h83, "status_full");
    cpu_read(DATA, 8'hA1, "pop_a1");
    cpu_read(DATA, 8'hB2, "pop_b2");
    cpu_read(DATA, 8'hC3, "pop_c3");
    cpu_read(DATA, 8'hD4, "pop_d4");
    cpu_read(STAT, 8'h00, "status_drained");

    // TX register, overflow, consume and flag clear.
    cpu_write(DATA, 8'h5A);
    check_output("tx_valid_5a", {7'd0, bus.out_valid}, 8'h01);
    check_output("tx_data_5a", bus.out_data, 8'h5A);
    cpu_read(STAT, 8'h04, "status_tx_busy");
    cpu_write(DATA, 8'h77);
    check_output("tx_data_kept", bus.out_data, 8'h5A);
    cpu_read(STAT, 8'h0C, "status_overflow");
    consume_byte(8'h5A);
    check_output("tx_valid_after_consume", {7'd0, bus.out_valid}, 8'h00);
    check_output("tx_data_held", bus.out_data, 8'h5A);
    cpu_read(STAT, 8'h08, "status_overflow_sticky");
    cpu_write(STAT, 8'h01);
    cpu_read(STAT, 8'h00, "status_cleared");

    // Underflow, undecoded address, and one pop per held strobe.
    cpu_read(DATA, 8'h00, "read_empty");
    cpu_read(STAT, 8'h10, "status_underflow");
    cpu_write(STAT, 8'h01);
    push_byte(8'h11);
    push_byte(8'h22);
    cpu_write(4'h3, 8'h99);
    check_output("undecoded_out_valid", {7'd0, bus.out_valid}, 8'h00);
    cpu_read(4'h3, 8'h00, "undecoded_read");
    cpu_read_hold(DATA, 8'h11, "held_read_first", 5);
    cpu_read(DATA, 8'h22, "held_read_second");
    cpu_read(STAT, 8'h00, "status_after_hold");

    // Read and write together: the write wins and the FIFO is not popped.
    push_byte(8'h44);
    cpu_read_write(DATA, 8'h55, 8'h44, "rw_head_visible");
    cpu_read(DATA, 8'h44, "rw_no_pop");
    consume_byte(8'h55);

    // Full FIFO with a waiting producer; a pop lets it in on the next edge.
    push_byte(8'h01);
    push_byte(8'h02);
    push_byte(8'h03);
    push_byte(8'h04);
    bus.in_data  = 8'hEE;
    bus.in_valid = 1'b1;
    #1;
    check_output("full_blocks_push", {7'd0, bus.in_ready}, 8'h00);
    cpu_read(DATA, 8'h01, "pop_while_full");
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    check_output("refilled_in_ready", {7'd0, bus.in_ready}, 8'h00);
    cpu_read(STAT, 8'h83, "status_refilled");
    cpu_read(DATA, 8'h02, "pop_02");
    cpu_read(DATA, 8'h03, "pop_03");
    cpu_read(DATA, 8'h04, "pop_04");
    cpu_read(DATA, 8'hEE, "pop_ee");

    // Pointer wrap-around with alternating push/pop.
    for (int i = 0; i < 10; i++) begin
      push_byte(8'h30 + 8'(i));
      cpu_read(DATA, 8'h30 + 8'(i), $sformatf("wrap_%0d", i));
    end

    // Asynchronous reset mid-stream.
    push_byte(8'h61);
    push_byte(8'h62);
    push_byte(8'h63);
    cpu_write(DATA, 8'h9C);
    cpu_write(DATA, 8'h9D);
    cpu_read(STAT, 8'h6D, "status_before_reset");
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check_output("async_in_ready", {7'd0, bus.in_ready}, 8'h01);
    check_output("async_out_valid", {7'd0, bus.out_valid}, 8'h00);
    check_output("async_out_data", bus.out_data, 8'h00);
    bus.address = STAT;
    bus.read    = 1'b1;
    #1;
    check_output("async_status", bus.data_out, 8'h00);
    bus.read = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    cpu_read(STAT, 8'h00, "status_after_reset");
    cpu_read(DATA, 8'h00, "fifo_empty_after_reset");
    cpu_write(STAT, 8'h01);
    push_byte(8'h7A);
    cpu_read(DATA, 8'h7A, "resume_pop");
    cpu_write(DATA, 8'h3C);
    check_output("resume_tx_valid", {7'd0, bus.out_valid}, 8'h01);
    check_output("resume_tx_data", bus.out_data, 8'h3C);
    consume_byte(8'h3C);
    check_output("resume_tx_done", {7'd0, bus.out_valid}, 8'h00);

    // Every queued expectation must have been observed.
    repeat (3) @(posedge clock);
    #1;
    check_output("rd_queue_drained", 8'(rd_exp_q.size()), 8'h00);
    check_output("tx_queue_drained", 8'(tx_exp_q.size()), 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
